aes128_encrypt_core: RTL and testbench

- Iterative AES-128 encryption engine (FIPS-197): one round per clock, round keys expanded on the fly.
- Sits in the scan-encryption path; encrypts a 128-bit block with a 128-bit key.
- Result is held on `cyphertext` until the next encryption completes.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_sbox.sv | 36 +++
 rtl/aes128_encrypt_core.sv | 123 ++++++++++++
 tb/tb_aes128_encrypt_core.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types, constants and GF(2^8) helpers for the AES-128 encryption core.
//   byte_t / word_t : byte and 32-bit word aliases
//   fsm_e           : control states of the iterative core (IDLE, RUN)
//   NR              : number of AES-128 rounds
//   rcon()          : round constant for rounds 1..10
//   xtime()         : multiply by {02} in GF(2^8)
//   mix_column()    : MixColumns transform of one 32-bit column
// -----------------------------------------------------------------------------
package aes_pkg;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_e;

   localparam int NR = 10;

   function automatic byte_t rcon(input logic [3:0] rnd);
      byte_t rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes a0..a3 sit MSB-first; matrix rows are [02 03 01 01] rotated.
   function automatic word_t mix_column(input word_t col);
      byte_t a0, a1, a2, a3;
      byte_t r0, r1, r2, r3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      return {r0, r1, r2, r3};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box lookup.
//   in_byte  : input byte
//   out_byte : S-box substitution of in_byte
// -----------------------------------------------------------------------------
module aes_sbox
   import aes_pkg::*;
(
   input  byte_t in_byte,
   output byte_t out_byte
);

   // Entry 0 is the leftmost byte of the concatenation.
   localparam logic [0:255][7:0] SBOX_ROM = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_byte = SBOX_ROM[in_byte];

endmodule

// File: rtl/aes128_encrypt_core.sv
// -----------------------------------------------------------------------------
// aes128_encrypt_core
// Iterative AES-128 encryption: one round per enabled clock, round keys
// expanded on the fly from the previous round key.
//   clk         : rising-edge clock
//   reset_n     : synchronous reset, ACTIVE-HIGH despite the name; beats en
//   start       : encryption request, honoured only in IDLE with en=1
//   en          : clock enable, en=0 freezes every register
//   plaintext   : input block, bits [127:120] = byte 0, column-major
//   initial_key : cipher key, same byte ordering
//   cyphertext  : registered result, held until the next encryption ends
// -----------------------------------------------------------------------------
module aes128_encrypt_core #(
   parameter int NR = aes_pkg::NR
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         en,
   input  logic [127:0] plaintext,
   input  logic [127:0] initial_key,
   output logic [127:0] cyphertext
);

   import aes_pkg::*;

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   fsm_e         fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [127:0] ct_q, ct_d;

   byte_t        sb_byte [16];
   logic [127:0] sr_state;
   logic [127:0] mc_state;
   word_t        sub_word;
   word_t        key_tmp;
   logic [127:0] rk_next;

   // SubBytes on every state byte
   for (genvar n = 0; n < 16; n++) begin : g_sub
      aes_sbox u_sbox (
         .in_byte  (state_q[127-8*n -: 8]),
         .out_byte (sb_byte[n])
      );
   end

   // ShiftRows: row r of column c takes the byte from column (c+r) mod 4
   for (genvar n = 0; n < 16; n++) begin : g_shift
      localparam int R = n % 4;
      localparam int C = n / 4;
      assign sr_state[127-8*n -: 8] = sb_byte[R + 4*((C + R) % 4)];
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mc_state[127-32*c -: 32] = mix_column(sr_state[127-32*c -: 32]);
   end

   // SubWord(RotWord(w3)): the rotation is folded into the sbox wiring
   aes_sbox u_kbox0 (.in_byte(key_q[23:16]), .out_byte(sub_word[31:24]));
   aes_sbox u_kbox1 (.in_byte(key_q[15:8]),  .out_byte(sub_word[23:16]));
   aes_sbox u_kbox2 (.in_byte(key_q[7:0]),   .out_byte(sub_word[15:8]));
   aes_sbox u_kbox3 (.in_byte(key_q[31:24]), .out_byte(sub_word[7:0]));

   assign key_tmp         = sub_word ^ {rcon(round_q), 24'h000000};
   assign rk_next[127:96] = key_q[127:96] ^ key_tmp;
   assign rk_next[95:64]  = key_q[95:64]  ^ rk_next[127:96];
   assign rk_next[63:32]  = key_q[63:32]  ^ rk_next[95:64];
   assign rk_next[31:0]   = key_q[31:0]   ^ rk_next[63:32];

   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      key_d   = key_q;
      ct_d    = ct_q;
      if (en) begin
         case (fsm_q)
            IDLE: begin
               if (start) begin
                  state_d = plaintext ^ initial_key;
                  key_d   = initial_key;
                  round_d = 4'd1;
                  fsm_d   = RUN;
               end
            end
            RUN: begin
               key_d = rk_next;
               if (round_q == LAST_ROUND) begin
                  // Final round skips MixColumns and lands straight in the output.
                  ct_d    = sr_state ^ rk_next;
                  round_d = 4'd0;
                  fsm_d   = IDLE;
               end else begin
                  state_d = mc_state ^ rk_next;
                  round_d = round_q + 4'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         fsm_q   <= IDLE;
         round_q <= 4'd0;
         state_q <= '0;
         key_q   <= '0;
         ct_q    <= '0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
         key_q   <= key_d;
         ct_q    <= ct_d;
      end
   end

   assign cyphertext = ct_q;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
module tb_aes128_encrypt_core;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic         en;
   logic [127:0] plaintext;
   logic [127:0] initial_key;
   logic [127:0] cyphertext;

   int n_tests = 0;
   int n_fail  = 0;

   logic [127:0] held;
   logic [7:0]   sbox_m [256];

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } kat_t;

   kat_t kat [3];

   aes128_encrypt_core #(.NR(10)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .en          (en),
      .plaintext   (plaintext),
      .initial_key (initial_key),
      .cyphertext  (cyphertext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         if (v != 0) begin
            for (int c = 1; c < 256; c++) begin
               if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            end
         end
         sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [127:0] out;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int n = 0; n < 16; n++) t[n] = sbox_m[s[n]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
               for (int r = 0; r < 4; r++)
                  s[4*c+r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
         end
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
      end
      for (int n = 0; n < 16; n++) out[127-8*n -: 8] = s[n];
      return out;
   endfunction

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Load, scramble the inputs, then expect the output held for 9 edges and
   // the result on the 10th edge after the load.
   task automatic encrypt_and_check(input string name, input logic [127:0] key,
                                    input logic [127:0] pt, input logic [127:0] exp);
      plaintext   = pt;
      initial_key = key;
      start       = 1'b1;
      en          = 1'b1;
      step();
      start       = 1'b0;
      plaintext   = rand128();
      initial_key = rand128();
      for (int i = 1; i <= 9; i++) begin
         step();
         check({name, "_hold"}, cyphertext, held);
      end
      step();
      check(name, cyphertext, exp);
      held = exp;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cnt;
      int guard;
      logic [127:0] k;
      logic [127:0] p;
      logic [127:0] e;

      kat[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                 pt:  128'h00112233445566778899aabbccddeeff,
                 ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      kat[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 pt:  128'h3243f6a8885a308d313198a2e0370734,
                 ct:  128'h3925841d02dc09fbdc118597196a0b32};
      kat[2] = '{key: 128'h00000000000000000000000000000000,
                 pt:  128'h00000000000000000000000000000000,
                 ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

      build_sbox();

      reset_n     = 1'b1;
      start       = 1'b0;
      en          = 1'b1;
      plaintext   = '0;
      initial_key = '0;
      held        = '0;
      step();
      step();
      check("reset_ct", cyphertext, 128'h0);
      reset_n = 1'b0;
      step();
      check("idle_ct", cyphertext, 128'h0);

      // Known-answer vectors
      for (int i = 0; i < 3; i++) begin
         encrypt_and_check($sformatf("kat%0d", i), kat[i].key, kat[i].pt, kat[i].ct);
      end

      // Random vectors against the model
      for (int i = 0; i < 6; i++) begin
         k = rand128();
         p = rand128();
         encrypt_and_check($sformatf("rand%0d", i), k, p, model_encrypt(k, p));
      end

      // Stall: start waits while en=0, then en drops for 3 edges after round 4
      plaintext   = kat[0].pt;
      initial_key = kat[0].key;
      start       = 1'b1;
      en          = 1'b0;
      step();
      step();
      check("no_load_when_disabled", cyphertext, held);
      en = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         check("stall_pre", cyphertext, held);
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold", cyphertext, held);
      end
      en = 1'b1;
      for (int i = 5; i <= 9; i++) begin
         step();
         check("stall_post", cyphertext, held);
      end
      step();
      check("stall_result", cyphertext, kat[0].ct);
      held = kat[0].ct;

      // Reset during round 5 (with en low, reset must still win)
      plaintext   = kat[0].pt;
      initial_key = kat[0].key;
      start       = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) step();
      reset_n = 1'b1;
      en      = 1'b0;
      step();
      check("midrun_reset_ct", cyphertext, 128'h0);
      held    = '0;
      reset_n = 1'b0;
      en      = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         check("post_reset_idle", cyphertext, held);
      end
      encrypt_and_check("after_reset_v2", kat[1].key, kat[1].pt, kat[1].ct);

      // Back-to-back with start held and inputs changed mid-run
      plaintext   = kat[0].pt;
      initial_key = kat[0].key;
      start       = 1'b1;
      step();
      plaintext   = kat[1].pt;
      initial_key = kat[1].key;
      for (int i = 1; i <= 9; i++) begin
         step();
         check("b2b_first_hold", cyphertext, held);
      end
      step();
      check("b2b_first", cyphertext, kat[0].ct);
      held = kat[0].ct;
      step();
      start = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         step();
         check("b2b_second_hold", cyphertext, held);
      end
      step();
      check("b2b_second", cyphertext, kat[1].ct);
      held = kat[1].ct;

      // Random enable gaps and stray start pulses during the run
      for (int i = 0; i < 4; i++) begin
         k           = rand128();
         p           = rand128();
         e           = model_encrypt(k, p);
         plaintext   = p;
         initial_key = k;
         start       = 1'b1;
         en          = 1'b1;
         step();
         cnt   = 0;
         guard = 0;
         while (cnt < 10 && guard < 200) begin
            en          = ($urandom_range(0, 3) != 0);
            start       = 1'($urandom_range(0, 1));
            plaintext   = rand128();
            initial_key = rand128();
            step();
            guard++;
            if (en) cnt++;
            if (cnt < 10) check("rand_en_hold", cyphertext, held);
         end
         start = 1'b0;
         en    = 1'b1;
         if (cnt < 10) begin
            n_tests++;
            n_fail++;
            $display("FAIL rand_en_timeout: got %0d enabled edges expected 10", cnt);
         end else begin
            check($sformatf("rand_en%0d", i), cyphertext, e);
         end
         held = e;
         step();
         check("rand_en_idle", cyphertext, held);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
